// File: rtl/bcd2bin_conv_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The requester drives master and the converter drives slave.
interface bcd2bin_conv_if #(
    parameter int NDIG = 3,
    parameter int BW   = 10
);
    logic              Start;
    logic [4*NDIG-1:0] Bcd;
    logic [BW-1:0]     Bin;
    logic              Done;
    logic              Err;
    logic              Busy;

    modport master (
        output Start, Bcd,
        input  Bin, Done, Err, Busy
    );

    modport slave (
        input  Start, Bcd,
        output Bin, Done, Err, Busy
    );
endinterface

// File: rtl/bcd2bin_conv.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// A start request loads the operand, and the result comes back with a one-cycle Done strobe.
module bcd2bin_conv #(
    parameter int NDIG = 3,
    parameter int BW   = 10
) (
    input  logic           Clock,
    input  logic           Rst_,
    bcd2bin_conv_if.slave  bus
);
    localparam int AW = 4 * NDIG;
    localparam int CW = $clog2(BW + 1);
    localparam logic [CW-1:0] BW_C = CW'(BW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_ADJ   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [AW-1:0]   a_r;
    logic [BW-1:0]   bin_r;
    logic [CW-1:0]   cnt_r;
    logic            err_r;
    logic            bcd_bad_s;

    // A digit at or above 8 holds a carried-in half of 10, so subtracting 3 keeps it decimal.
    function automatic logic [AW-1:0] adj_digits(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i+3]) begin
                r[4*i +: 4] = a[4*i +: 4] - 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [AW-1:0] a);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    assign bcd_bad_s = has_bad_digit(bus.Bcd);

    // State register.
    always_ff @(posedge Clock) begin
        if (!Rst_) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.Start) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bcd_bad_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_SHIFT: state_s = S_ADJ;
            S_ADJ: begin
                if (cnt_r == BW_C) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: operand shift register, result, iteration count and error flag.
    always_ff @(posedge Clock) begin
        if (!Rst_) begin
            a_r   <= {AW{1'b0}};
            bin_r <= {BW{1'b0}};
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    a_r   <= bus.Bcd;
                    bin_r <= {BW{1'b0}};
                    cnt_r <= {CW{1'b0}};
                    err_r <= bcd_bad_s;
                end
                S_SHIFT: begin
                    a_r   <= {1'b0, a_r[AW-1:1]};
                    bin_r <= {a_r[0], bin_r[BW-1:1]};
                    cnt_r <= cnt_r + CW'(1);
                end
                S_ADJ: begin
                    a_r <= adj_digits(a_r);
                end
                default: begin
                    a_r   <= a_r;
                    bin_r <= bin_r;
                    cnt_r <= cnt_r;
                    err_r <= err_r;
                end
            endcase
        end
    end

    assign bus.Bin  = bin_r;
    assign bus.Err  = err_r;
    assign bus.Done = (state_r == S_DONE);
    assign bus.Busy = (state_r != S_IDLE);
endmodule

// File: tb/tb_bcd2bin_conv.sv
// Directed bench for bcd2bin_conv: latency, known values, full sweep, error path,
// ignored starts and mid-conversion reset.
module tb_bcd2bin_conv;
    logic Clock = 1'b0;
    logic Rst_  = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    bcd2bin_conv_if #(.NDIG(3), .BW(10)) bus ();

    bcd2bin_conv #(.NDIG(3), .BW(10)) dut (
        .Clock (Clock),
        .Rst_  (Rst_),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Pulse Start with an operand and check latency (edges counted from the sampling edge) and result.
    task automatic run_conv(input logic [11:0] bcd, input int exp_bin, input int exp_err, input int exp_lat);
        int lat;
        lat = 0;
        bus.Start = 1'b1;
        bus.Bcd   = bcd;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (n == 1) begin
                bus.Start = 1'b0;
                check("busy_rise", 32'(bus.Busy), 32'd1);
            end
            if (bus.Done) lat = n;
        end
        check("latency", lat, exp_lat);
        check("bin", 32'(bus.Bin), exp_bin);
        check("err", 32'(bus.Err), exp_err);
        tick();
        check("done_one_cycle", 32'(bus.Done), 32'd0);
        check("busy_fall", 32'(bus.Busy), 32'd0);
        check("bin_held", 32'(bus.Bin), exp_bin);
        check("err_held", 32'(bus.Err), exp_err);
    endtask

    initial begin
        int lat;
        int dones;
        int d2, d1, d0;
        logic [11:0] bcd_v;

        bus.Start = 1'b0;
        bus.Bcd   = 12'h000;

        // Reset state
        tick(); tick();
        check("rst_bin", 32'(bus.Bin), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_err", 32'(bus.Err), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        Rst_ = 1'b1;
        tick();

        // Known values
        run_conv(12'h000, 0, 0, 22);
        run_conv(12'h999, 999, 0, 22);
        run_conv(12'h255, 255, 0, 22);
        run_conv(12'h100, 100, 0, 22);
        run_conv(12'h001, 1, 0, 22);
        run_conv(12'h512, 512, 0, 22);

        // Invalid digit, then a valid conversion clears Err
        run_conv(12'h1A3, 0, 1, 2);
        run_conv(12'h042, 42, 0, 22);
        run_conv(12'hF00, 0, 1, 2);
        run_conv(12'h00A, 0, 1, 2);

        // Full sweep with Start held high: Done every 23 edges after the first
        bus.Start = 1'b1;
        dones = 0;
        for (int v = 0; v < 1000; v++) begin
            d2 = v / 100;
            d1 = (v / 10) % 10;
            d0 = v % 10;
            bcd_v = {d2[3:0], d1[3:0], d0[3:0]};
            bus.Bcd = bcd_v;
            lat = 0;
            for (int n = 1; n <= 40 && lat == 0; n++) begin
                tick();
                if (bus.Done) lat = n;
            end
            if (lat != 0) dones++;
            check("sweep_lat", lat, (v == 0) ? 22 : 23);
            check("sweep_bin", 32'(bus.Bin), v);
            check("sweep_err", 32'(bus.Err), 32'd0);
        end
        bus.Start = 1'b0;
        check("sweep_dones", dones, 1000);
        tick(); tick(); tick();
        check("sweep_idle", 32'(bus.Busy), 32'd0);

        // Start pulses in cycles 5 and 21 of a busy conversion are ignored
        bus.Start = 1'b1;
        bus.Bcd   = 12'h512;
        dones = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            bus.Start = (n == 5 || n == 21) ? 1'b1 : 1'b0;
            if (n == 6) bus.Bcd = 12'h777;
            if (bus.Done) begin
                dones++;
                check("ign_lat", n, 22);
                check("ign_bin", 32'(bus.Bin), 32'd512);
            end
        end
        check("ign_dones", dones, 1);
        check("ign_busy", 32'(bus.Busy), 32'd0);

        // Reset for one edge during cycle 10 aborts the conversion
        bus.Start = 1'b1;
        bus.Bcd   = 12'h777;
        for (int n = 1; n <= 10; n++) begin
            tick();
            bus.Start = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.Busy), 32'd1);
        Rst_ = 1'b0;
        tick();
        Rst_ = 1'b1;
        check("abort_bin", 32'(bus.Bin), 32'd0);
        check("abort_done", 32'(bus.Done), 32'd0);
        check("abort_err", 32'(bus.Err), 32'd0);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (bus.Done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_conv(12'h777, 777, 0, 22);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bcd2bin_conv.md
# bcd2bin_conv

Sequential BCD-to-binary converter. It is the inverse of the team's binary-to-BCD shift-add-3 block, and it uses reverse double dabble: shift right, then subtract 3 from any BCD digit ≥ 8. Control FSM and datapath sit in one module. The block takes a packed NDIG-digit BCD word on a Start pulse and returns the binary value with a one-cycle Done strobe. It flags non-decimal digits instead of converting them.

## Interface
- NDIG, 3: number of BCD digits converted.
- BW, 10: binary result width; must satisfy 2^BW > 10^NDIG − 1 (10 for 3 digits).
- Clock  in  1  rising-edge clock for all state.
- Rst_  in  1  reset: one clock; reset is synchronous and active-low.
- Start  in  1  conversion request, sampled only in IDLE.
- Bcd  in  4*NDIG  packed BCD operand, digit 0 in [3:0]; sampled in LOAD only.
- Bin  out  BW  binary result, registered; valid when Done=1 and held until the next LOAD.
- Done  out  1  one-cycle completion strobe.
- Err  out  1  asserted with Done when any input digit > 9; held with Bin until the next LOAD.
- Busy  out  1  high in every state except IDLE.

## Operation
- Registers: A (4*NDIG bits, BCD shift register), Bin (BW bits), iteration counter cnt (enough bits to hold BW), state.
- IDLE:
  - Done=0, Busy=0.
  - Start=1 → LOAD; otherwise stay.
- LOAD:
  - A ← Bcd; Bin ← 0; cnt ← 0; Err ← (any Bcd digit > 9).
  - Any digit invalid → DONE.
  - Otherwise → SHIFT.
- SHIFT:
  - {A, Bin} ← {1'b0, A, Bin} >> 1, i.e. A[0] enters Bin[BW−1].
  - cnt ← cnt+1.
  - → ADJ.
- ADJ:
  - For every digit d of A independently: if d ≥ 8 then d ← d − 3, else d unchanged. Digit arithmetic is 4-bit; no borrow crosses digit boundaries.
  - If cnt == BW → DONE, else → SHIFT.
- DONE:
  - Done=1 for exactly this cycle.
  - → IDLE unconditionally.
  - Start is not sampled here.
- After BW iterations, A is all-zero for any valid input. Bin equals the decimal value of Bcd.
- Error path: Bin stays 0 and Err=1 with Done.
- Start high while not in IDLE is ignored; it is neither queued nor restarting.
- Start held high continuously gives back-to-back conversions with one IDLE cycle between them.
- Bcd changes after LOAD have no effect on the conversion in progress.

## Timing
- Reset: synchronous. Rst_=0 at a rising edge forces the following:
  - state → IDLE;
  - A, Bin, cnt → 0;
  - Done, Err, Busy → 0.
- Reset asserted mid-conversion aborts it on that edge. No Done is produced for the aborted conversion.
- Valid conversion:
  - cycle 0: IDLE with Start=1;
  - cycle 1: LOAD;
  - cycles 2 to 2·BW+1: SHIFT/ADJ pairs;
  - cycle 2·BW+2: DONE.
  - With BW=10, Done is high in cycle 22, i.e. 22 clocks after the Start-sampling edge.
- Invalid input: cycle 1 LOAD, cycle 2 DONE with Err=1.
- Bin and Err are stable from the DONE cycle until the next LOAD edge.
- Done, Err and Busy are registered or decoded from registered state only. There is no combinational path from Start or Bcd to any output.
- Busy rises in the cycle after Start is sampled and falls in the cycle after DONE.

## Test plan
- Reset, then Bcd=12'h000 with Start pulse → Done in cycle 22; Bin=10'd0, Err=0.
- Bcd=12'h999 → Bin=10'd999 (0x3E7), Err=0. Also Bcd=12'h255 → Bin=0x0FF, and Bcd=12'h100 → Bin=0x064. Each Done lands exactly 22 cycles after Start.
- Sweep all 1000 valid inputs with back-to-back Start held high. Every result equals the decimal value, and exactly one Done occurs per conversion.
- Bcd=12'h1A3 (digit 1 = A) → Done in cycle 2 with Err=1, Bin=0. A following valid conversion of 12'h042 clears Err and gives Bin=42.
- Start pulses in cycles 5 and 21 during a busy conversion of 12'h512 → ignored; a single Done with Bin=512.
- Rst_=0 for one edge at cycle 10 of a conversion → IDLE next cycle with Bin=0, Done=Err=Busy=0. No Done follows, and a new Start then converts normally.
